// File: rtl/rgb_blink.sv
// RGB LED demo: 8N1 UART command receiver driving a blinking colour mask.
// Define RGB_BLINK_ECHO_EN to build the transmitter that echoes accepted bytes on uarttx.
module rgb_blink #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned BLINK_BITS   = 24
) (
  input  logic       hw_clk,
  input  logic       rst_n,
  input  logic       uartrx,
  output logic       uarttx,
  output logic       led_red,
  output logic       led_green,
  output logic       led_blue,
  output logic       rx_valid,
  output logic [7:0] rx_data
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e             rx_state_q, rx_state_d;
  logic [1:0]            sync_q, sync_d;
  logic [1:0]            flush_q, flush_d;
  logic                  armed_q, armed_d;
  logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic [2:0]            rx_idx_q, rx_idx_d;
  logic [7:0]            rx_shift_q, rx_shift_d;
  logic [7:0]            rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [2:0]            mask_q, mask_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic [2:0]            led_q, led_d;
  logic                  rx_sync;

  assign rx_sync = sync_q[1];

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      sync_q     <= 2'b11;
      flush_q    <= 2'b00;
      armed_q    <= 1'b0;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      mask_q     <= 3'b100;
      blink_q    <= '0;
      led_q      <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      sync_q     <= sync_d;
      flush_q    <= flush_d;
      armed_q    <= armed_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      mask_q     <= mask_d;
      blink_q    <= blink_d;
      led_q      <= led_d;
    end
  end

  // Receiver next state, command decode, blink and LED gating.
  always_comb begin
    rx_state_d = rx_state_q;
    sync_d     = {sync_q[0], uartrx};
    flush_d    = {flush_q[0], 1'b1};
    armed_d    = armed_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    mask_d     = mask_q;
    blink_d    = blink_q + BLINK_BITS'(1);
    led_d      = mask_q & {3{blink_q[BLINK_BITS-1]}};

    // The synchroniser resets to 1; ignore it until real line samples have flushed through.
    if (flush_q[1] && rx_sync) armed_d = 1'b1;

    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (armed_q && !rx_sync) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync, rx_shift_q[7:1]};
          rx_idx_d   = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end else begin
            armed_d = 1'b0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // Forcing bit 5 folds upper-case letters onto lower case.
    if (rx_valid_q) begin
      case (rx_data_q | 8'h20)
        8'h72:   mask_d = 3'b100;
        8'h67:   mask_d = 3'b010;
        8'h62:   mask_d = 3'b001;
        8'h77:   mask_d = 3'b111;
        8'h6f:   mask_d = 3'b000;
        default: mask_d = mask_q;
      endcase
    end
  end

  assign led_red   = led_q[2];
  assign led_green = led_q[1];
  assign led_blue  = led_q[0];
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;

`ifdef RGB_BLINK_ECHO_EN
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_q, tx_d;

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  // Echo transmitter; bytes accepted while busy are dropped.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;

    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (rx_valid_q) begin
          tx_shift_d = rx_data_q;
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_idx_d   = tx_idx_q + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign uarttx = tx_q;
`else
  assign uarttx = 1'b1;
`endif

endmodule

// File: tb/tb_rgb_blink.sv
// Directed bench for rgb_blink: UART byte driver with rx/echo scoreboards and an LED blink model.
module tb_rgb_blink;

  localparam int CPB = 104;
  localparam int BB  = 6;

  logic       hw_clk;
  logic       rst_n;
  logic       uartrx;
  logic       uarttx;
  logic       led_red;
  logic       led_green;
  logic       led_blue;
  logic       rx_valid;
  logic [7:0] rx_data;

  int total = 0;
  int bad   = 0;
  int n;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx_exp;
  logic [9:0] tx_obs;
  logic [9:0] tx_exp;
  logic       tx_prev = 1'b1;

  rgb_blink #(.CLKS_PER_BIT(CPB), .BLINK_BITS(BB)) dut (
    .hw_clk    (hw_clk),
    .rst_n     (rst_n),
    .uartrx    (uartrx),
    .uarttx    (uarttx),
    .led_red   (led_red),
    .led_green (led_green),
    .led_blue  (led_blue),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data)
  );

  initial hw_clk = 1'b0;
  always #5 hw_clk = ~hw_clk;

  // Clock edges since reset release; the blink counter must equal this modulo 2^BB.
  always @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  // Receive scoreboard: every rx_valid pulse must match the next expected byte.
  always @(negedge hw_clk) begin
    if (rst_n === 1'b1 && rx_valid === 1'b1) begin
      total++;
      if (rx_q.size() == 0) begin
        assert (rx_valid === 1'b0)
          else begin bad++; $error("FAIL unexpected_rx_valid got=%0b exp=0 data=%02h", rx_valid, rx_data); end
      end else begin
        rx_exp = rx_q.pop_front();
        assert (rx_data === rx_exp)
          else begin bad++; $error("FAIL rx_data got=%02h exp=%02h", rx_data, rx_exp); end
      end
    end
  end

  // Transmit scoreboard: decode any frame on uarttx mid-bit and compare start/data/stop.
  always @(negedge hw_clk) begin
    if (rst_n === 1'b1 && tx_prev === 1'b1 && uarttx === 1'b0) begin
      repeat (CPB / 2) @(negedge hw_clk);
      tx_obs[0] = uarttx;
      for (int i = 1; i < 10; i++) begin
        repeat (CPB) @(negedge hw_clk);
        tx_obs[i] = uarttx;
      end
      total++;
      tx_exp = (tx_q.size() > 0) ? {1'b1, tx_q.pop_front(), 1'b0} : 10'h3ff;
      assert (tx_obs === tx_exp)
        else begin bad++; $error("FAIL tx_frame got=%b exp=%b (bit0=start)", tx_obs, tx_exp); end
    end
    tx_prev = uarttx;
  end

  task automatic put_bit(input logic v);
    uartrx = v;
    repeat (CPB) @(posedge hw_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit accept,
                           input bit echo, input int gap_bits);
    if (accept) rx_q.push_back(b);
`ifdef RGB_BLINK_ECHO_EN
    if (echo) tx_q.push_back(b);
`else
    if (echo) tx_q.delete();
`endif
    put_bit(1'b0);
    for (int i = 0; i < 8; i++) put_bit(b[i]);
    put_bit(stop_bit);
    uartrx = 1'b1;
    repeat (gap_bits * CPB) @(posedge hw_clk);
    #1;
  endtask

  task automatic check_leds(input logic [2:0] m, input int cycles);
    logic [2:0] exp_l;
    logic       ph;
    for (int i = 0; i < cycles; i++) begin
      @(negedge hw_clk);
      ph    = 1'((n - 1) >> (BB - 1));
      exp_l = m & {3{ph}};
      total++;
      assert ({led_red, led_green, led_blue} === exp_l)
        else begin bad++; $error("FAIL leds n=%0d got=%03b exp=%03b", n, {led_red, led_green, led_blue}, exp_l); end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    assert ({led_red, led_green, led_blue, rx_valid, uarttx} === 5'b00001)
      else begin bad++; $error("FAIL %s_ctrl got=%05b exp=00001", tag, {led_red, led_green, led_blue, rx_valid, uarttx}); end
    total++;
    assert (rx_data === 8'h00)
      else begin bad++; $error("FAIL %s_rx_data got=%02h exp=00", tag, rx_data); end
  endtask

  initial begin
    rst_n  = 1'b0;
    uartrx = 1'b0;
    #100;
    check_reset_outputs("reset");
    #160;
    rst_n  = 1'b1;
    uartrx = 1'b1;
    repeat (2 * CPB) @(posedge hw_clk);
    check_leds(3'b100, 140);

    send_byte(8'h67, 1'b1, 1'b1, 1'b1, 12);          // 'g'
    check_leds(3'b010, 70);

    send_byte(8'h57, 1'b1, 1'b1, 1'b1, 0);           // 'W' then 'o' back-to-back
    send_byte(8'h6f, 1'b1, 1'b1, 1'b0, 12);          // echo still busy with 'W'
    check_leds(3'b000, 70);

    send_byte(8'h57, 1'b1, 1'b1, 1'b1, 12);          // 'W'
    check_leds(3'b111, 70);

    send_byte(8'h78, 1'b1, 1'b1, 1'b1, 12);          // 'x' is not a command
    check_leds(3'b111, 70);

    send_byte(8'h41, 1'b0, 1'b0, 1'b0, 3);           // framing error
    check_leds(3'b111, 70);
    send_byte(8'h62, 1'b1, 1'b1, 1'b1, 12);          // 'b'
    check_leds(3'b001, 70);

    uartrx = 1'b0;                                   // short glitch
    repeat (10) @(posedge hw_clk);
    #1;
    uartrx = 1'b1;
    repeat (2 * CPB) @(posedge hw_clk);
    check_leds(3'b001, 70);
    send_byte(8'h72, 1'b1, 1'b1, 1'b1, 12);          // 'r', echoed 0,0,1,0,0,1,1,1,0,1
    check_leds(3'b100, 70);

    send_byte(8'h47, 1'b1, 1'b1, 1'b1, 12);          // 'G'
    check_leds(3'b010, 70);

    put_bit(1'b0);                                   // reset mid-frame, line held low
    put_bit(1'b1);
    put_bit(1'b0);
    rst_n = 1'b0;
    repeat (20) @(posedge hw_clk);
    #1;
    check_reset_outputs("midframe_reset");
    rst_n = 1'b1;
    repeat (2000) @(posedge hw_clk);
    check_leds(3'b100, 70);
    uartrx = 1'b1;
    repeat (2 * CPB) @(posedge hw_clk);
    #1;
    send_byte(8'h62, 1'b1, 1'b1, 1'b1, 12);          // 'b' after re-arm
    check_leds(3'b001, 70);

    total++;
    assert (rx_q.size() === 0)
      else begin bad++; $error("FAIL rx_pending got=%0d exp=0", rx_q.size()); end
    total++;
    assert (tx_q.size() === 0)
      else begin bad++; $error("FAIL tx_pending got=%0d exp=0", tx_q.size()); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
